// File: rtl/calc_input_cond_if.sv
// Pin-side and datapath-side signals of the calculator input-conditioning stage.
// master drives the raw pins; slave is the conditioning block.
interface calc_input_cond_if #(
  parameter int SW_BITS = 8,
  parameter int BT_BITS = 4
);
  logic [SW_BITS-1:0]   sw_in;
  logic [BT_BITS-1:0]   bt_in;
  logic [SW_BITS/2-1:0] a;
  logic [SW_BITS/2-1:0] b;
  logic [BT_BITS-1:0]   op_sel;
  logic                 op_strobe;
  logic                 opnd_strobe;
  logic [1:0]           range_err;

  modport master (
    output sw_in, bt_in,
    input  a, b, op_sel, op_strobe, opnd_strobe, range_err
  );

  modport slave (
    input  sw_in, bt_in,
    output a, b, op_sel, op_strobe, opnd_strobe, range_err
  );
endinterface

// File: rtl/calc_input_cond.sv
// Synchronise and debounce calculator switches/buttons, latch the operation select.
// Optional macro CALC_INPUT_OP_TOGGLE_EN: re-pressing the selected button blanks op_sel.
module calc_input_cond #(
  parameter int SW_BITS = 8,
  parameter int BT_BITS = 4,
  parameter int DEB_CNT = 160000,
  parameter int CNT_W   = 18
) (
  input  logic             clk16M,
  input  logic             rst,
  calc_input_cond_if.slave io
);

  localparam int HALF = SW_BITS / 2;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

  function automatic logic [BT_BITS-1:0] lowest_one_hot(input logic [BT_BITS-1:0] v);
    logic [BT_BITS-1:0] r;
    r = '0;
    for (int i = BT_BITS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [SW_BITS-1:0] sw_meta_p0, sw_sync_p1, sw_last_p1, sw_deb_p2;
  logic [CNT_W-1:0]   sw_cnt_p2;
  logic               vld_p2;

  logic [BT_BITS-1:0] bt_meta_p0, bt_sync_p1, bt_deb_p2, bt_deb_p3;
  logic [CNT_W-1:0]   bt_cnt_p2 [BT_BITS];
  logic [BT_BITS-1:0] bt_rise_p3;

  logic [HALF-1:0]    a_p3, b_p3;
  logic [1:0]         range_err_p3;
  logic               opnd_strobe_p3;
  logic [BT_BITS-1:0] op_sel_p3;
  logic               op_strobe_p3;

  // p0/p1: two-flop synchronisers; p2: shared-counter bus debounce
  always_ff @(posedge clk16M) begin
    if (rst) begin
      sw_meta_p0 <= '0;
      sw_sync_p1 <= '0;
      sw_last_p1 <= '0;
      sw_deb_p2  <= '0;
      sw_cnt_p2  <= '0;
      vld_p2     <= 1'b0;
    end else begin
      sw_meta_p0 <= io.sw_in;
      sw_sync_p1 <= sw_meta_p0;
      sw_last_p1 <= sw_sync_p1;
      vld_p2     <= 1'b0;
      if (sw_sync_p1 == sw_deb_p2) begin
        sw_cnt_p2 <= '0;
      end else if ((sw_sync_p1 != sw_last_p1) && (sw_last_p1 != sw_deb_p2)) begin
        // bus moved to yet another value while already counting
        sw_cnt_p2 <= '0;
      end else if (sw_cnt_p2 == DEB_LAST) begin
        sw_deb_p2 <= sw_sync_p1;
        sw_cnt_p2 <= '0;
        vld_p2    <= 1'b1;
      end else begin
        sw_cnt_p2 <= sw_cnt_p2 + CNT_W'(1);
      end
    end
  end

  // p0/p1: button synchronisers; p2: per-button debounce
  always_ff @(posedge clk16M) begin
    if (rst) begin
      bt_meta_p0 <= '0;
      bt_sync_p1 <= '0;
      bt_deb_p2  <= '0;
      for (int i = 0; i < BT_BITS; i++) bt_cnt_p2[i] <= '0;
    end else begin
      bt_meta_p0 <= io.bt_in;
      bt_sync_p1 <= bt_meta_p0;
      for (int i = 0; i < BT_BITS; i++) begin
        if (bt_sync_p1[i] == bt_deb_p2[i]) begin
          bt_cnt_p2[i] <= '0;
        end else if (bt_cnt_p2[i] == DEB_LAST) begin
          bt_deb_p2[i] <= bt_sync_p1[i];
          bt_cnt_p2[i] <= '0;
        end else begin
          bt_cnt_p2[i] <= bt_cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    bt_rise_p3 = lowest_one_hot(bt_deb_p2 & ~bt_deb_p3);
  end

  // p3: registered outputs
  always_ff @(posedge clk16M) begin
    if (rst) begin
      a_p3           <= '0;
      b_p3           <= '0;
      range_err_p3   <= '0;
      opnd_strobe_p3 <= 1'b0;
      bt_deb_p3      <= '0;
      op_sel_p3      <= '0;
      op_strobe_p3   <= 1'b0;
    end else begin
      a_p3           <= sw_deb_p2[SW_BITS-1:HALF];
      b_p3           <= sw_deb_p2[HALF-1:0];
      range_err_p3   <= {sw_deb_p2[SW_BITS-1:HALF] > HALF'(9),
                         sw_deb_p2[HALF-1:0] > HALF'(9)};
      opnd_strobe_p3 <= vld_p2;
      bt_deb_p3      <= bt_deb_p2;
      op_strobe_p3   <= |bt_rise_p3;
      if (|bt_rise_p3) begin
`ifdef CALC_INPUT_OP_TOGGLE_EN
        if ((op_sel_p3 & bt_rise_p3) != '0) op_sel_p3 <= '0;
        else                                op_sel_p3 <= bt_rise_p3;
`else
        op_sel_p3 <= bt_rise_p3;
`endif
      end
    end
  end

  assign io.a           = a_p3;
  assign io.b           = b_p3;
  assign io.range_err   = range_err_p3;
  assign io.opnd_strobe = opnd_strobe_p3;
  assign io.op_sel      = op_sel_p3;
  assign io.op_strobe   = op_strobe_p3;

endmodule

// File: tb/tb_calc_input_cond.sv
// Scoreboard bench for calc_input_cond with a short debounce count.
module tb_calc_input_cond;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;  // drive at negedge -> visible at negedge after edge DEB+2

  logic clk16M = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] rerr;
    int         cyc;
  } opnd_exp_t;

  typedef struct {
    logic [3:0] sel;
    int         cyc;
  } op_exp_t;

  opnd_exp_t opnd_q[$];
  op_exp_t   op_q[$];

  calc_input_cond_if #(.SW_BITS(8), .BT_BITS(4)) io ();

  calc_input_cond #(.SW_BITS(8), .BT_BITS(4), .DEB_CNT(DEB), .CNT_W(18)) dut (
    .clk16M (clk16M),
    .rst    (rst),
    .io     (io.slave)
  );

  always #31 clk16M = ~clk16M;
  always @(posedge clk16M) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk16M);
  endtask

  task automatic push_sw(input logic [7:0] v);
    opnd_exp_t e;
    e.a    = v[7:4];
    e.b    = v[3:0];
    e.rerr = {v[7:4] > 4'd9, v[3:0] > 4'd9};
    e.cyc  = cyc + LAT;
    opnd_q.push_back(e);
  endtask

  task automatic push_op(input logic [3:0] sel);
    op_exp_t e;
    e.sel = sel;
    e.cyc = cyc + LAT;
    op_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((opnd_q.size() + op_q.size()) != 0 && k < 100) begin
      tick(1);
      k++;
    end
    check(tag, opnd_q.size() + op_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, int'(io.a), 0);
    check({tag, "_b"}, int'(io.b), 0);
    check({tag, "_op_sel"}, int'(io.op_sel), 0);
    check({tag, "_range_err"}, int'(io.range_err), 0);
    check({tag, "_strobes"}, int'({io.op_strobe, io.opnd_strobe}), 0);
  endtask

  // Output monitor: every strobe must match the next queued expectation
  always @(negedge clk16M) begin
    if (rst === 1'b0) begin
      if (io.opnd_strobe) begin
        check("opnd_strobe_expected", int'(opnd_q.size() > 0), 1);
        if (opnd_q.size() > 0) begin
          opnd_exp_t e;
          e = opnd_q.pop_front();
          check("opnd_cycle", cyc, e.cyc);
          check("a", int'(io.a), int'(e.a));
          check("b", int'(io.b), int'(e.b));
          check("range_err", int'(io.range_err), int'(e.rerr));
        end
      end
      if (io.op_strobe) begin
        check("op_strobe_expected", int'(op_q.size() > 0), 1);
        if (op_q.size() > 0) begin
          op_exp_t e;
          e = op_q.pop_front();
          check("op_cycle", cyc, e.cyc);
          check("op_sel", int'(io.op_sel), int'(e.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] sw_tbl [5];
    sw_tbl[0] = 8'h37;
    sw_tbl[1] = 8'hC0;
    sw_tbl[2] = 8'h0F;
    sw_tbl[3] = 8'hFF;
    sw_tbl[4] = 8'hA5;

    rst = 1'b1;
    io.sw_in = 8'h00;
    io.bt_in = 4'b0000;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_zero("post_reset");
    tick(20);
    check_zero("idle");

    for (int i = 0; i < 5; i++) begin
      io.sw_in = sw_tbl[i];
      push_sw(sw_tbl[i]);
      tick(15);
      drain("sw_drain");
    end

    // short glitch must be ignored
    io.sw_in = 8'h00;
    tick(2);
    io.sw_in = 8'hA5;
    tick(15);
    check("glitch_a", int'(io.a), 4'hA);
    check("glitch_b", int'(io.b), 4'h5);
    check("glitch_range_err", int'(io.range_err), 2);

    io.bt_in = 4'b0100;
    push_op(4'b0100);
    tick(10);
    io.bt_in = 4'b0000;
    tick(15);
    drain("bt_drain");
    check("release_op_sel", int'(io.op_sel), 4'b0100);

    io.bt_in = 4'b1010;
    push_op(4'b0010);
    tick(10);
    io.bt_in = 4'b0000;
    tick(15);
    drain("simul_drain");
    check("simul_op_sel", int'(io.op_sel), 4'b0010);

    io.bt_in = 4'b0010;
`ifdef CALC_INPUT_OP_TOGGLE_EN
    push_op(4'b0000);
`else
    push_op(4'b0010);
`endif
    tick(10);
    io.bt_in = 4'b0000;
    tick(15);
    drain("repress_drain");

    // reset in the middle of a debounce count
    io.sw_in = 8'h99;
    tick(3);
    rst = 1'b1;
    tick(1);
    check_zero("mid_reset");
    rst = 1'b0;
    push_sw(8'h99);
    tick(15);
    drain("post_reset_drain");
    check("final_a", int'(io.a), 9);
    check("final_b", int'(io.b), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
